qft4_sequencer: RTL and testbench

Sequencer for the 4-point quantum Fourier transform state-vector datapath. It accepts one 4-element complex state vector over a valid/ready handshake and holds it stable on the datapath inputs. Over four cycles it drives the twiddle-factor row for each output index k and captures the datapath result. It then streams the four transformed amplitudes out over a second valid/ready handshake, and sits between the state-vector source and whatever consumes the transformed amplitudes.

---
 rtl/qft4_sequencer_pkg.sv | 29 ++
 rtl/qft4_sequencer_if.sv | 54 +++++
 rtl/qft4_twiddle_rom.sv | 30 +++
 rtl/qft4_sequencer.sv | 176 +++++++++++++++++
 tb/tb_qft4_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qft4_sequencer_pkg.sv
// Shared constants, types and the twiddle-index helper for the 4-point QFT sequencer.
package qft4_sequencer_pkg;

  localparam int unsigned N     = 4;
  localparam int unsigned AMP_W = 8;
  localparam int unsigned TW_W  = 12;
  localparam int unsigned RES_W = 13;

  typedef logic signed [AMP_W-1:0] amp_t;
  typedef logic signed [TW_W-1:0]  tw_t;
  typedef logic signed [RES_W-1:0] res_t;

  // Unity in Q1.10.
  localparam tw_t TW_ONE = 12'sd1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOut  = 2'd2
  } state_e;

  // Twiddle exponent m = (j*k) mod 4; the 2-bit result width does the modulo.
  function automatic logic [1:0] tw_index(input logic [1:0] k, input logic [1:0] j);
    logic [1:0] m;
    m = k * j;
    return m;
  endfunction

endpackage

// File: rtl/qft4_sequencer_if.sv
// Bundle of the vector input, datapath and result output signals of the QFT sequencer.
// The inverse input exists only when QFT_INVERSE_EN is defined.
interface qft4_sequencer_if;
  import qft4_sequencer_pkg::*;

  logic in_valid;
  logic in_ready;
  amp_t in_r0, in_r1, in_r2, in_r3;
  amp_t in_i0, in_i1, in_i2, in_i3;
`ifdef QFT_INVERSE_EN
  logic inverse;
`endif

  amp_t dp_r0, dp_r1, dp_r2, dp_r3;
  amp_t dp_i0, dp_i1, dp_i2, dp_i3;
  tw_t  dp_cos0, dp_cos1, dp_cos2, dp_cos3;
  tw_t  dp_sin0, dp_sin1, dp_sin2, dp_sin3;
  res_t dp_out_r, dp_out_i;

  logic       out_valid;
  logic       out_ready;
  res_t       out_r, out_i;
  logic [1:0] out_idx;
  logic       busy;

  // Environment side: vector source, datapath and result sink.
  modport master (
    output in_valid, in_r0, in_r1, in_r2, in_r3, in_i0, in_i1, in_i2, in_i3,
`ifdef QFT_INVERSE_EN
    output inverse,
`endif
    input  in_ready,
    input  dp_r0, dp_r1, dp_r2, dp_r3, dp_i0, dp_i1, dp_i2, dp_i3,
    input  dp_cos0, dp_cos1, dp_cos2, dp_cos3, dp_sin0, dp_sin1, dp_sin2, dp_sin3,
    output dp_out_r, dp_out_i,
    input  out_valid, out_r, out_i, out_idx, busy,
    output out_ready
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_r0, in_r1, in_r2, in_r3, in_i0, in_i1, in_i2, in_i3,
`ifdef QFT_INVERSE_EN
    input  inverse,
`endif
    output in_ready,
    output dp_r0, dp_r1, dp_r2, dp_r3, dp_i0, dp_i1, dp_i2, dp_i3,
    output dp_cos0, dp_cos1, dp_cos2, dp_cos3, dp_sin0, dp_sin1, dp_sin2, dp_sin3,
    input  dp_out_r, dp_out_i,
    output out_valid, out_r, out_i, out_idx, busy,
    input  out_ready
  );

endinterface

// File: rtl/qft4_twiddle_rom.sv
// Combinational twiddle lookup for one column j of the 4-point QFT: (k, j, inverse) -> (cos, sin).
module qft4_twiddle_rom
  import qft4_sequencer_pkg::*;
(
  input  logic [1:0] k_i,
  input  logic [1:0] j_i,
  input  logic       inverse_i,
  output tw_t        cos_o,
  output tw_t        sin_o
);

  logic [1:0] m;
  tw_t        sin_fwd;

  always_comb begin
    m       = tw_index(k_i, j_i);
    cos_o   = '0;
    sin_fwd = '0;
    unique case (m)
      2'd0:    cos_o   = TW_ONE;
      2'd1:    sin_fwd = TW_ONE;
      2'd2:    cos_o   = -TW_ONE;
      2'd3:    sin_fwd = -TW_ONE;
      default: cos_o   = '0;
    endcase
    // Conjugate twiddles give the inverse transform.
    sin_o = inverse_i ? -sin_fwd : sin_fwd;
  end

endmodule

// File: rtl/qft4_sequencer.sv
// 4-point QFT sequencer: load vector, step twiddle rows k=0..3 capturing results, stream them out.
// Optional QFT_INVERSE_EN adds an inverse input latched with the vector.
module qft4_sequencer
  import qft4_sequencer_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  qft4_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [1:0] p_q, p_d;

  amp_t vec_r_q [N];
  amp_t vec_i_q [N];
  res_t buf_r_q [N];
  res_t buf_i_q [N];

  amp_t in_r_w [N];
  amp_t in_i_w [N];
  tw_t  rom_cos [N];
  tw_t  rom_sin [N];
  tw_t  tw_cos [N];
  tw_t  tw_sin [N];

  logic load, capture, inv_w;

  assign in_r_w = '{bus.in_r0, bus.in_r1, bus.in_r2, bus.in_r3};
  assign in_i_w = '{bus.in_i0, bus.in_i1, bus.in_i2, bus.in_i3};

`ifdef QFT_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (load) begin
      inv_q <= bus.inverse;
    end
  end

  assign inv_w = inv_q;
`else
  assign inv_w = 1'b0;
`endif

  for (genvar j = 0; j < N; j++) begin : g_tw
    qft4_twiddle_rom u_rom (
      .k_i       (k_q),
      .j_i       (2'(j)),
      .inverse_i (inv_w),
      .cos_o     (rom_cos[j]),
      .sin_o     (rom_sin[j])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      p_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StRun;
          k_d     = 2'd0;
        end
      end
      StRun: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = StOut;
          p_d     = 2'd0;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          p_d = p_q + 2'd1;
          if (p_q == 2'd3) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    load          = 1'b0;
    capture       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_r     = '0;
    bus.out_i     = '0;
    for (int unsigned j = 0; j < N; j++) begin
      tw_cos[j] = '0;
      tw_sin[j] = '0;
    end
    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        load         = bus.in_valid;
      end
      StRun: begin
        capture = 1'b1;
        for (int unsigned j = 0; j < N; j++) begin
          tw_cos[j] = rom_cos[j];
          tw_sin[j] = rom_sin[j];
        end
      end
      StOut: begin
        bus.out_valid = 1'b1;
        bus.out_r     = buf_r_q[p_q];
        bus.out_i     = buf_i_q[p_q];
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.out_idx = p_q;

  // Vector and result storage; cleared by reset so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < N; j++) begin
        vec_r_q[j] <= '0;
        vec_i_q[j] <= '0;
        buf_r_q[j] <= '0;
        buf_i_q[j] <= '0;
      end
    end else begin
      if (load) begin
        vec_r_q <= in_r_w;
        vec_i_q <= in_i_w;
      end
      if (capture) begin
        buf_r_q[k_q] <= bus.dp_out_r;
        buf_i_q[k_q] <= bus.dp_out_i;
      end
    end
  end

  assign bus.dp_r0   = vec_r_q[0];
  assign bus.dp_r1   = vec_r_q[1];
  assign bus.dp_r2   = vec_r_q[2];
  assign bus.dp_r3   = vec_r_q[3];
  assign bus.dp_i0   = vec_i_q[0];
  assign bus.dp_i1   = vec_i_q[1];
  assign bus.dp_i2   = vec_i_q[2];
  assign bus.dp_i3   = vec_i_q[3];
  assign bus.dp_cos0 = tw_cos[0];
  assign bus.dp_cos1 = tw_cos[1];
  assign bus.dp_cos2 = tw_cos[2];
  assign bus.dp_cos3 = tw_cos[3];
  assign bus.dp_sin0 = tw_sin[0];
  assign bus.dp_sin1 = tw_sin[1];
  assign bus.dp_sin2 = tw_sin[2];
  assign bus.dp_sin3 = tw_sin[3];

endmodule

// File: tb/tb_qft4_sequencer.sv
// Directed testbench for qft4_sequencer with a behavioural datapath returning sum(in_j*w_jk)/2.
module tb_qft4_sequencer;
  import qft4_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  qft4_sequencer_if bus ();

  qft4_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: complex dot product with the twiddle row, scaled by 1/1024 and halved.
  int model_r, model_i;
  always_comb begin
    model_r = 0;
    model_i = 0;
    model_r = bus.dp_r0 * bus.dp_cos0 - bus.dp_i0 * bus.dp_sin0
            + bus.dp_r1 * bus.dp_cos1 - bus.dp_i1 * bus.dp_sin1
            + bus.dp_r2 * bus.dp_cos2 - bus.dp_i2 * bus.dp_sin2
            + bus.dp_r3 * bus.dp_cos3 - bus.dp_i3 * bus.dp_sin3;
    model_i = bus.dp_r0 * bus.dp_sin0 + bus.dp_i0 * bus.dp_cos0
            + bus.dp_r1 * bus.dp_sin1 + bus.dp_i1 * bus.dp_cos1
            + bus.dp_r2 * bus.dp_sin2 + bus.dp_i2 * bus.dp_cos2
            + bus.dp_r3 * bus.dp_sin3 + bus.dp_i3 * bus.dp_cos3;
    bus.dp_out_r = 13'(model_r / 2048);
    bus.dp_out_i = 13'(model_i / 2048);
  end

  res_t       got_r [4];
  res_t       got_i [4];
  logic [1:0] got_idx [4];
  res_t       exp_r [4];
  res_t       exp_i [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int r0, input int r1, input int r2, input int r3,
                         input int i0, input int i1, input int i2, input int i3);
    bus.in_r0 = 8'(r0); bus.in_r1 = 8'(r1); bus.in_r2 = 8'(r2); bus.in_r3 = 8'(r3);
    bus.in_i0 = 8'(i0); bus.in_i1 = 8'(i1); bus.in_i2 = 8'(i2); bus.in_i3 = 8'(i3);
  endtask

  // Offers the current vector; returns one cycle after the accepting edge.
  task automatic send(output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output bit ok);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (bus.out_valid) begin
        got_r[n]   = bus.out_r;
        got_i[n]   = bus.out_i;
        got_idx[n] = bus.out_idx;
        n++;
      end
      step();
    end
    ok = (n == 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.out_idx !== 2'd0 || bus.out_r !== 13'sd0 || bus.out_i !== 13'sd0) begin
      failures++;
      $display("FAIL reset_out: idx=%0d r=%0d i=%0d want 0 0 0", bus.out_idx, bus.out_r, bus.out_i);
    end
    checks++;
    if (bus.dp_r0 !== 8'sd0 || bus.dp_i3 !== 8'sd0 || bus.dp_cos0 !== 12'sd0
        || bus.dp_sin1 !== 12'sd0) begin
      failures++;
      $display("FAIL reset_dp: dp_r0=%0d dp_i3=%0d cos0=%0d sin1=%0d want all 0",
               bus.dp_r0, bus.dp_i3, bus.dp_cos0, bus.dp_sin1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_tone();
    bit ok;
    set_vec(0, 4, 0, 0, 0, 0, 0, 0);
    send(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tone_accept: got 0 want 1"); end
    // Now in the k=0 row.
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.dp_r1 !== 8'sd4) begin
      failures++;
      $display("FAIL tone_run: busy=%b in_ready=%b dp_r1=%0d want 1 0 4",
               bus.busy, bus.in_ready, bus.dp_r1);
    end
    checks++;
    if (bus.dp_cos1 !== 12'sd1024 || bus.dp_sin1 !== 12'sd0) begin
      failures++;
      $display("FAIL tone_tw_k0: cos1=%0d sin1=%0d want 1024 0", bus.dp_cos1, bus.dp_sin1);
    end
    step();
    checks++;
    if (bus.dp_cos1 !== 12'sd0 || bus.dp_sin1 !== 12'sd1024 || bus.dp_cos2 !== -12'sd1024
        || bus.dp_sin3 !== -12'sd1024) begin
      failures++;
      $display("FAIL tone_tw_k1: cos1=%0d sin1=%0d cos2=%0d sin3=%0d want 0 1024 -1024 -1024",
               bus.dp_cos1, bus.dp_sin1, bus.dp_cos2, bus.dp_sin3);
    end
    collect(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tone_collect: got 0 want 1"); end
    exp_r = '{13'sd2, 13'sd0, -13'sd2, 13'sd0};
    exp_i = '{13'sd0, 13'sd2, 13'sd0, -13'sd2};
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (got_r[n] !== exp_r[n] || got_i[n] !== exp_i[n] || got_idx[n] !== 2'(n)) begin
        failures++;
        $display("FAIL tone_sample[%0d]: got (%0d,%0d) idx %0d want (%0d,%0d) idx %0d",
                 n, got_r[n], got_i[n], got_idx[n], exp_r[n], exp_i[n], n);
      end
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.dp_cos0 !== 12'sd0 || bus.dp_r1 !== 8'sd4) begin
      failures++;
      $display("FAIL tone_idle: in_ready=%b cos0=%0d dp_r1=%0d want 1 0 4",
               bus.in_ready, bus.dp_cos0, bus.dp_r1);
    end
  endtask

  task automatic test_dc_latency();
    bit ok;
    int lat;
    set_vec(4, 4, 4, 4, 0, 0, 0, 0);
    send(ok);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 5) begin failures++; $display("FAIL dc_latency: got %0d want 5", lat); end
    collect(ok);
    exp_r = '{13'sd8, 13'sd0, 13'sd0, 13'sd0};
    exp_i = '{13'sd0, 13'sd0, 13'sd0, 13'sd0};
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (got_r[n] !== exp_r[n] || got_i[n] !== exp_i[n] || got_idx[n] !== 2'(n)) begin
        failures++;
        $display("FAIL dc_sample[%0d]: got (%0d,%0d) idx %0d want (%0d,%0d) idx %0d",
                 n, got_r[n], got_i[n], got_idx[n], exp_r[n], exp_i[n], n);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n, stall, bad;
    set_vec(0, 4, 0, 0, 0, 0, 0, 0);
    send(ok);
    n = 0;
    stall = 0;
    bad = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (bus.out_valid) begin
        if (n == 2 && stall < 3) begin
          bus.out_ready = 1'b0;
          stall++;
          checks++;
          if (bus.out_r !== -13'sd2 || bus.out_i !== 13'sd0 || bus.out_idx !== 2'd2
              || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d]: got (%0d,%0d) idx %0d in_ready %b want (-2,0) idx 2 0",
                     stall, bus.out_r, bus.out_i, bus.out_idx, bus.in_ready);
          end
        end else begin
          bus.out_ready = 1'b1;
          got_r[n]   = bus.out_r;
          got_i[n]   = bus.out_i;
          got_idx[n] = bus.out_idx;
          n++;
        end
      end
      step();
    end
    bus.out_ready = 1'b1;
    checks++;
    if (n != 4 || stall != 3) begin
      failures++;
      $display("FAIL bp_count: samples %0d stalls %0d want 4 3", n, stall);
    end
    exp_r = '{13'sd2, 13'sd0, -13'sd2, 13'sd0};
    exp_i = '{13'sd0, 13'sd2, 13'sd0, -13'sd2};
    for (int k = 0; k < 4; k++) begin
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k] || got_idx[k] !== 2'(k)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_sequence: bad samples %0d want 0", bad); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc;
    set_vec(0, 4, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0: got 0 want 1"); end
    step();
    set_vec(4, 4, 4, 4, 0, 0, 0, 0);
    acc = -1;
    for (int c = 1; c <= 15; c++) begin
      if (c == 5) begin
        checks++;
        if (bus.dp_r0 !== 8'sd0 || bus.dp_r1 !== 8'sd4) begin
          failures++;
          $display("FAIL b2b_dp_hold: dp_r0=%0d dp_r1=%0d want 0 4", bus.dp_r0, bus.dp_r1);
        end
      end
      if (bus.in_ready) begin
        acc = c;
        break;
      end
      step();
    end
    checks++;
    if (acc != 9) begin failures++; $display("FAIL b2b_accept_cycle: got %0d want 9", acc); end
    step();
    bus.in_valid = 1'b0;
    collect(ok);
    exp_r = '{13'sd8, 13'sd0, 13'sd0, 13'sd0};
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (got_r[n] !== exp_r[n] || got_i[n] !== 13'sd0) begin
        failures++;
        $display("FAIL b2b_sample[%0d]: got (%0d,%0d) want (%0d,0)", n, got_r[n], got_i[n],
                 exp_r[n]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int seen_valid, not_ready;
    set_vec(0, 4, 0, 0, 0, 0, 0, 0);
    send(ok);
    step();
    step();
    // k=2 row is active here.
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    checks++;
    if (bus.dp_r1 !== 8'sd0 || bus.dp_cos0 !== 12'sd0 || bus.out_r !== 13'sd0
        || bus.out_idx !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_data: dp_r1=%0d cos0=%0d out_r=%0d idx=%0d want all 0",
               bus.dp_r1, bus.dp_cos0, bus.out_r, bus.out_idx);
    end
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen_valid = 0;
    not_ready = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.out_valid) seen_valid++;
      if (!bus.in_ready) not_ready++;
    end
    checks++;
    if (seen_valid != 0 || not_ready != 0) begin
      failures++;
      $display("FAIL rst_mid_after: out_valid cycles %0d not-ready cycles %0d want 0 0",
               seen_valid, not_ready);
    end
  endtask

`ifdef QFT_INVERSE_EN
  task automatic test_inverse();
    bit ok;
    set_vec(0, 4, 0, 0, 0, 0, 0, 0);
    bus.inverse = 1'b1;
    send(ok);
    bus.inverse = 1'b0;
    collect(ok);
    exp_r = '{13'sd2, 13'sd0, -13'sd2, 13'sd0};
    exp_i = '{13'sd0, -13'sd2, 13'sd0, 13'sd2};
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (got_r[n] !== exp_r[n] || got_i[n] !== exp_i[n]) begin
        failures++;
        $display("FAIL inv_sample[%0d]: got (%0d,%0d) want (%0d,%0d)", n, got_r[n], got_i[n],
                 exp_r[n], exp_i[n]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef QFT_INVERSE_EN
    bus.inverse = 1'b0;
`endif
    test_reset();
    test_single_tone();
    test_dc_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef QFT_INVERSE_EN
    test_inverse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
